// File: rtl/fft_pkg.sv
// Shared constants, width helpers and FSM states for the FFT power stages.
// Used by fft_power_avg, its interface and the bin magnitude unit.
package fft_pkg;

    localparam int DEF_W            = 8;
    localparam int DEF_N            = 32;
    localparam int DEF_MAX_AVG_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DUMP
    } state_t;

    // Folded power width: one bit above r^2+i^2 for the doubled bins.
    function automatic int PW(input int w);
        return 2 * w + 1;
    endfunction

    // Accumulator width: folded power plus frame-average headroom.
    function automatic int ACCW(input int w, input int max_avg_log2);
        return PW(w) + max_avg_log2;
    endfunction

    // Width of a one-sided bin index 0..N/2.
    function automatic int BINW(input int n);
        return $clog2(n / 2 + 1);
    endfunction

endpackage

// File: rtl/fft_power_avg_if.sv
// Bin stream in / averaged spectrum out handshake bundle.
// slave: the power averager; master: the bin source and spectrum sink.
interface fft_power_avg_if
    import fft_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sop;
    logic signed [W-1:0]   in_r;
    logic signed [W-1:0]   in_i;

    logic                  out_valid;
    logic                  out_ready;
    logic [BINW(N)-1:0]    out_bin;
    logic [PW(W)-1:0]      out_pwr;
    logic                  out_last;

    modport slave (
        input  in_valid, in_sop, in_r, in_i, out_ready,
        output in_ready, out_valid, out_bin, out_pwr, out_last
    );

    modport master (
        output in_valid, in_sop, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_bin, out_pwr, out_last
    );

endinterface

// File: rtl/fft_bin_mag2.sv
// Combinational squared magnitude of one complex bin: r^2 + i^2.
// Ports: i_r/i_i signed W-bit parts; o_mag unsigned 2W-bit result.
module fft_bin_mag2 #(
    parameter int W = 8
) (
    input  logic signed [W-1:0]   i_r,
    input  logic signed [W-1:0]   i_i,
    output logic [2*W-1:0]        o_mag
);

    logic signed [2*W-1:0] w_re;
    logic signed [2*W-1:0] w_im;
    logic signed [2*W-1:0] w_rr;
    logic signed [2*W-1:0] w_ii;

    assign w_re = {{W{i_r[W-1]}}, i_r};
    assign w_im = {{W{i_i[W-1]}}, i_i};
    assign w_rr = w_re * w_re;
    assign w_ii = w_im * w_im;

    // Each square is at most 2^(2W-2), so the unsigned sum fits 2W bits.
    assign o_mag = $unsigned(w_rr) + $unsigned(w_ii);

endmodule

// File: rtl/fft_power_avg.sv
// Streaming folded one-sided power with 2^avg_log2 frame averaging.
// Ports: clk, arst (async, active-high), avg_log2, err pulse, bus (slave).
module fft_power_avg
    import fft_pkg::*;
#(
    parameter int W            = DEF_W,
    parameter int N            = DEF_N,
    parameter int MAX_AVG_LOG2 = DEF_MAX_AVG_LOG2
) (
    input  logic                              clk,
    input  logic                              arst,
    input  logic [$clog2(MAX_AVG_LOG2+1)-1:0] avg_log2,
    output logic                              err,
    fft_power_avg_if.slave                    bus
);

    localparam int PWW  = PW(W);
    localparam int AW   = ACCW(W, MAX_AVG_LOG2);
    localparam int BW   = BINW(N);
    localparam int CW   = $clog2(N);
    localparam int LW   = $clog2(MAX_AVG_LOG2 + 1);
    localparam int FW   = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;
    localparam int HALF = N / 2;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_bin_cnt;
    logic [FW-1:0]   r_frame_cnt;
    logic [LW-1:0]   r_avg;
    logic [AW-1:0]   r_acc [0:HALF];
    logic [BW-1:0]   r_dump_idx;
    logic            r_in_ready;
    logic            r_err;
    logic            r_out_valid;
    logic [BW-1:0]   r_out_bin;
    logic [PWW-1:0]  r_out_pwr;
    logic            r_out_last;

    logic [2*W-1:0]  w_mag;
    logic            w_hs;
    logic [LW-1:0]   w_clamp;
    logic [CW:0]     w_fold;
    logic [BW-1:0]   w_addr;
    logic [AW-1:0]   w_add;
    logic [AW-1:0]   w_add0;
    logic [FW:0]     w_fmax;
    logic            w_frames_done;
    logic            w_last_bin;
    logic            w_start;
    logic            w_acc;
    logic            w_err;
    logic            w_load;

    fft_bin_mag2 #(.W(W)) u_mag (
        .i_r   (bus.in_r),
        .i_i   (bus.in_i),
        .o_mag (w_mag)
    );

    assign w_hs    = bus.in_valid && r_in_ready;
    assign w_clamp = (avg_log2 > LW'(MAX_AVG_LOG2)) ? LW'(MAX_AVG_LOG2)
                                                     : avg_log2;

    // Fold bin k onto min(k, N-k); bins 0 and N/2 have no mirror.
    assign w_fold = (r_bin_cnt > CW'(HALF))
                  ? (CW+1)'(N) - {1'b0, r_bin_cnt}
                  : {1'b0, r_bin_cnt};
    assign w_addr = BW'(w_fold);
    assign w_add0 = AW'({w_mag, 1'b0});
    assign w_add  = (w_addr == '0 || w_addr == BW'(HALF))
                  ? w_add0 : AW'(w_mag);

    assign w_fmax        = (FW+1)'((1 << r_avg) - 1);
    assign w_frames_done = ({1'b0, r_frame_cnt} == w_fmax);
    assign w_last_bin    = (r_bin_cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_acc   = 1'b0;
        w_err   = 1'b0;
        w_load  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_hs) begin
                    if (bus.in_sop) begin
                        w_start = 1'b1;
                        w_next  = ACC;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ACC: begin
                if (w_hs) begin
                    if (r_bin_cnt == '0) begin
                        if (bus.in_sop) w_acc = 1'b1;
                        else            w_err = 1'b1;
                    end else if (bus.in_sop) begin
                        // Lost framing: restart the run on this beat.
                        w_err   = 1'b1;
                        w_start = 1'b1;
                    end else begin
                        w_acc = 1'b1;
                    end
                    if (w_acc && w_last_bin && w_frames_done)
                        w_next = DUMP;
                end
            end
            DUMP: begin
                w_load = (r_dump_idx <= BW'(HALF))
                      && (!r_out_valid || bus.out_ready);
                if (r_out_valid && bus.out_ready && r_out_last)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_bin_cnt   <= '0;
            r_frame_cnt <= '0;
            r_avg       <= '0;
            r_in_ready  <= 1'b0;
            r_err       <= 1'b0;
            r_dump_idx  <= '0;
        end else begin
            r_err      <= w_err;
            r_in_ready <= (w_next != DUMP);
            if (w_start) begin
                r_bin_cnt   <= CW'(1);
                r_frame_cnt <= '0;
                r_avg       <= w_clamp;
            end else if (w_acc) begin
                r_bin_cnt <= r_bin_cnt + 1'b1;
                if (w_last_bin && !w_frames_done)
                    r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (r_state != DUMP) r_dump_idx <= '0;
            else if (w_load)     r_dump_idx <= r_dump_idx + 1'b1;
        end
    end

    // Entries are zeroed as they are dumped, so a new run starts clean.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int j = 0; j <= HALF; j++) r_acc[j] <= '0;
        end else begin
            for (int j = 0; j <= HALF; j++) begin
                if (w_start)
                    r_acc[j] <= (j == 0) ? w_add0 : '0;
                else if (w_acc && w_addr == BW'(j))
                    r_acc[j] <= r_acc[j] + w_add;
                else if (w_load && r_dump_idx == BW'(j))
                    r_acc[j] <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_out_valid <= 1'b0;
            r_out_bin   <= '0;
            r_out_pwr   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_bin   <= r_dump_idx;
            r_out_pwr   <= PWW'(r_acc[r_dump_idx] >> r_avg);
            r_out_last  <= (r_dump_idx == BW'(HALF));
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_bin   = r_out_bin;
    assign bus.out_pwr   = r_out_pwr;
    assign bus.out_last  = r_out_last;
    assign err           = r_err;

endmodule
